// File: rtl/round_robin_arbiter.sv
// Four-requester round-robin arbiter. Every ownership handoff passes through one IDLE cycle.
// Define ARB_TIMEOUT_EN to revoke a grant after MAX_HOLD cycles and pulse timeout.
module round_robin_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    output logic       gnt0,
    output logic       gnt1,
    output logic       gnt2,
    output logic       gnt3,
    output logic [1:0] gnt_addr,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     r_state;
    logic [1:0] r_ptr;
    logic [1:0] r_addr;
    logic [3:0] r_gnt;
    logic [7:0] r_cnt;
    logic       r_timeout;

    state_t     w_state;
    logic [1:0] w_ptr;
    logic [1:0] w_addr;
    logic [3:0] w_gnt;
    logic [7:0] w_cnt;
    logic       w_timeout;
    logic [1:0] w_pick;
    logic [1:0] w_cand;

    // Select the first active request at or above ptr, wrapping 3->0.
    always_comb begin
        w_pick = r_ptr;
        w_cand = r_ptr;
        for (int i = 3; i >= 0; i--) begin
            w_cand = r_ptr + 2'(i);
            w_pick = req[w_cand] ? w_cand : w_pick;
        end
    end

    // Next-state and next-output computation.
    always_comb begin
        w_state   = r_state;
        w_ptr     = r_ptr;
        w_addr    = r_addr;
        w_gnt     = r_gnt;
        w_cnt     = r_cnt;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_state = ST_GRANT;
                    w_addr  = w_pick;
                    w_ptr   = w_pick + 2'd1;
                    w_gnt   = 4'b0001 << w_pick;
                    w_cnt   = 8'd0;
                end else begin
                    w_gnt   = 4'b0000;
                end
            end
            ST_GRANT: begin
                if (!req[r_addr]) begin
                    w_state = ST_IDLE;
                    w_gnt   = 4'b0000;
`ifdef ARB_TIMEOUT_EN
                end else if (r_cnt == HOLD_LAST) begin
                    w_state   = ST_IDLE;
                    w_gnt     = 4'b0000;
                    w_timeout = 1'b1;
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
`else
                // Without revocation the counter only saturates; it never ends a grant.
                end else if (r_cnt != HOLD_LAST) begin
                    w_cnt = r_cnt + 8'd1;
                end else begin
                    w_cnt = r_cnt;
                end
`endif
            end
            default: begin
                w_state = ST_IDLE;
                w_gnt   = 4'b0000;
            end
        endcase
    end

    // State and output registers; reset drops any grant immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= 2'd0;
            r_addr    <= 2'd0;
            r_gnt     <= 4'b0000;
            r_cnt     <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_ptr     <= w_ptr;
            r_addr    <= w_addr;
            r_gnt     <= w_gnt;
            r_cnt     <= w_cnt;
            r_timeout <= w_timeout;
        end
    end

    assign gnt0      = r_gnt[0];
    assign gnt1      = r_gnt[1];
    assign gnt2      = r_gnt[2];
    assign gnt3      = r_gnt[3];
    assign gnt_addr  = r_addr;
    assign gnt_valid = (r_state == ST_GRANT);
    assign timeout   = r_timeout;

endmodule

// File: doc/round_robin_arbiter.md
ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 8, max consecutive grant cycles per owner when timeout is compiled in (legal 2..255).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req  input  4  request lines; bit i = requester i, held high until done.
REQ-005 Port: gnt0, gnt1, gnt2, gnt3  output  1 each  one-hot grant lines, registered.
REQ-006 Port: gnt_addr  output  2  index of current or last owner, registered.
REQ-007 Port: gnt_valid  output  1  high while any grant line is high.
REQ-008 Port: timeout  output  1  one-cycle pulse on forced revocation.

Function
REQ-009 Two states: IDLE (no grant) and GRANT (exactly one owner).
REQ-010 Grant lines SHALL equal a 2-to-4 decode of gnt_addr enabled by gnt_valid; gnt_valid=0 forces all four low.
REQ-011 At most one grant line SHALL be high in any cycle.
REQ-012 IDLE, req==0: stay IDLE, outputs unchanged except gnt_valid=0.
REQ-013 IDLE, req!=0: next edge enter GRANT, owner = first set bit searching upward from ptr, wrapping 3->0; latency from req to grant = 1 cycle.
REQ-014 ptr (2-bit) SHALL be set to owner+1 (mod 4) on every grant issue; 3+1 wraps to 0.
REQ-015 GRANT, req[owner]=1: hold grant; req changes on other bits ignored.
REQ-016 GRANT, req[owner]=0: next edge return to IDLE, gnt_valid=0 for at least one cycle before any new grant.
REQ-017 Grant SHALL never pass directly owner-to-owner; every handoff includes one IDLE cycle.
REQ-018 Same-cycle multiple new requests SHALL resolve by REQ-013 only; no fixed priority.
REQ-019 gnt_addr SHALL retain last owner in IDLE.
REQ-020 Hold counter (8-bit) SHALL clear on grant issue and increment each GRANT cycle.

Reset
REQ-021 reset_n low SHALL immediately force IDLE, gnt0..gnt3=0, gnt_valid=0, gnt_addr=0, ptr=0, counter=0, timeout=0, regardless of clk.
REQ-022 Reset asserted mid-grant SHALL drop the grant asynchronously; after release, first grant follows REQ-013 with ptr=0.
REQ-023 Reset deassertion SHALL take effect on the first rising edge after reset_n goes high.

Configuration
REQ-024 Macro ARB_TIMEOUT_EN defined: when counter reaches MAX_HOLD-1 in GRANT with req[owner]=1, next edge revoke grant, enter IDLE, pulse timeout for that one cycle.
REQ-025 After revocation, ptr already past owner; a sole requester SHALL be regranted after the IDLE cycle.
REQ-026 Macro ARB_TIMEOUT_EN undefined: no revocation, timeout tied 0, grant held indefinitely while req[owner]=1; counter may be omitted.

Verification
REQ-027 Reset, req=4'b0000 for 5 cycles -> all grants 0, gnt_valid=0, gnt_addr=0.
REQ-028 After reset req=4'b1010 -> one cycle later gnt1=1, gnt_addr=1; drop req[1] -> IDLE one cycle -> gnt3=1, gnt_addr=3.
REQ-029 req=4'b1111 held, each owner drops then re-raises its req one cycle after IDLE -> grant order 0,1,2,3,0 with an IDLE cycle between each.
REQ-030 ARB_TIMEOUT_EN, MAX_HOLD=8, req=4'b0001 held -> gnt0 high 8 cycles, timeout=1 with gnt_valid=0 one cycle, gnt0 regranted next cycle; undefined -> gnt0 never drops.
REQ-031 Grant to requester 2 active, reset_n pulsed low mid-cycle -> gnt2 falls without clk edge; after release with req=4'b0100, gnt2 one cycle later, ptr=3.
REQ-032 Every test: assertion that grant lines are one-hot-or-zero and match decode(gnt_addr, gnt_valid) each cycle.
